nibble_serial_accumulator: RTL and testbench



---
 rtl/nibble_serial_accumulator.sv | 157 +++++++++++++++
 tb/tb_nibble_serial_accumulator.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_accumulator.sv
// Sums a window of KERNEL_SIZE 8-bit pixels one nibble per cycle through an external 4-bit adder.
// Optional saturation and overflow flag is enabled by defining NIBBLE_ACC_SAT_EN.
module nibble_serial_accumulator #(
  parameter int KERNEL_SIZE = 9,
  parameter int ACC_W       = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [7:0]       pix_data,
  output logic             pix_ready,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_c0,
  input  logic [3:0]       add_s,
  input  logic             add_c4,
  output logic [ACC_W-1:0] sum,
  output logic             sum_valid,
  input  logic             sum_ready
`ifdef NIBBLE_ACC_SAT_EN
  ,
  output logic             sum_ovf
`endif
);

  localparam int NIB = ACC_W / 4;
  localparam int NCW = $clog2(NIB);
  localparam int PCW = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  localparam logic [NCW-1:0] NIB_LAST = NCW'(NIB - 1);
  localparam logic [PCW-1:0] PIX_LAST = PCW'(KERNEL_SIZE - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] operand;
  logic             carry;
  logic [NCW-1:0]   nib_cnt;
  logic [PCW-1:0]   pix_cnt;
  logic             last_nib;
  logic             last_pix;

`ifdef NIBBLE_ACC_SAT_EN
  logic ovf_flag;
`endif

  assign last_nib = (nib_cnt == NIB_LAST);
  assign last_pix = (pix_cnt == PIX_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Adder ports depend only on registered state, never on add_s/add_c4.
  always_comb begin
    state_next = state;
    pix_ready  = 1'b0;
    sum_valid  = 1'b0;
    sum        = '0;
    add_a      = 4'h0;
    add_b      = 4'h0;
    add_c0     = 1'b0;
`ifdef NIBBLE_ACC_SAT_EN
    sum_ovf    = 1'b0;
`endif
    case (state)
      IDLE: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          state_next = ADD;
        end
      end
      ADD: begin
        add_a  = acc[3:0];
        add_b  = operand[3:0];
        add_c0 = (nib_cnt == '0) ? 1'b0 : carry;
        if (last_nib) begin
          state_next = last_pix ? DONE : IDLE;
        end
      end
      DONE: begin
        sum_valid = 1'b1;
`ifdef NIBBLE_ACC_SAT_EN
        sum     = ovf_flag ? '1 : acc;
        sum_ovf = ovf_flag;
`else
        sum     = acc;
`endif
        if (sum_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The accumulator rotates right one nibble per ADD cycle, so it is realigned after NIB cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      operand <= '0;
      carry   <= 1'b0;
      nib_cnt <= '0;
      pix_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pix_valid) begin
            operand <= ACC_W'(pix_data);
            carry   <= 1'b0;
            nib_cnt <= '0;
          end
        end
        ADD: begin
          acc     <= {add_s, acc[ACC_W-1:4]};
          operand <= operand >> 4;
          carry   <= add_c4;
          nib_cnt <= last_nib ? '0 : nib_cnt + NCW'(1);
          if (last_nib) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + PCW'(1);
          end
        end
        DONE: begin
          if (sum_ready) begin
            acc <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef NIBBLE_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (state == DONE && sum_ready) begin
      ovf_flag <= 1'b0;
    end else if (state == ADD && last_nib && add_c4) begin
      ovf_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Bench for nibble_serial_accumulator: a 12-bit/9-pixel instance and an 8-bit/2-pixel instance,
// each wired to a behavioural 4-bit adder; directed table, hand sequences and random windows.
module tb_nibble_serial_accumulator;

  typedef logic [7:0] pix_q_t[$];

  typedef struct {
    bit         sel;
    int         n;
    logic [7:0] pix[9];
    int         exp_sum;
    bit         exp_ovf;
    bit         lat;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic rst;

  logic        pix_valid_b, pix_ready_b, add_c0_b, add_c4_b, sum_valid_b, sum_ready_b;
  logic [7:0]  pix_data_b;
  logic [3:0]  add_a_b, add_b_b, add_s_b;
  logic [11:0] sum_b;

  logic        pix_valid_s, pix_ready_s, add_c0_s, add_c4_s, sum_valid_s, sum_ready_s;
  logic [7:0]  pix_data_s;
  logic [3:0]  add_a_s, add_b_s, add_s_s;
  logic [7:0]  sum_s;

`ifdef NIBBLE_ACC_SAT_EN
  logic sum_ovf_b, sum_ovf_s;
`endif

  // Behavioural stand-ins for the external 4-bit adder.
  always_comb {add_c4_b, add_s_b} = 5'(add_a_b) + 5'(add_b_b) + 5'(add_c0_b);
  always_comb {add_c4_s, add_s_s} = 5'(add_a_s) + 5'(add_b_s) + 5'(add_c0_s);

  nibble_serial_accumulator #(.KERNEL_SIZE(9), .ACC_W(12)) dut (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid_b), .pix_data(pix_data_b), .pix_ready(pix_ready_b),
    .add_a(add_a_b), .add_b(add_b_b), .add_c0(add_c0_b),
    .add_s(add_s_b), .add_c4(add_c4_b),
    .sum(sum_b), .sum_valid(sum_valid_b), .sum_ready(sum_ready_b)
`ifdef NIBBLE_ACC_SAT_EN
    , .sum_ovf(sum_ovf_b)
`endif
  );

  nibble_serial_accumulator #(.KERNEL_SIZE(2), .ACC_W(8)) dut_small (
    .clk(clk), .rst(rst),
    .pix_valid(pix_valid_s), .pix_data(pix_data_s), .pix_ready(pix_ready_s),
    .add_a(add_a_s), .add_b(add_b_s), .add_c0(add_c0_s),
    .add_s(add_s_s), .add_c4(add_c4_s),
    .sum(sum_s), .sum_valid(sum_valid_s), .sum_ready(sum_ready_s)
`ifdef NIBBLE_ACC_SAT_EN
    , .sum_ovf(sum_ovf_s)
`endif
  );

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic rdy(input bit sel);
    return sel ? pix_ready_s : pix_ready_b;
  endfunction

  function automatic logic vld(input bit sel);
    return sel ? sum_valid_s : sum_valid_b;
  endfunction

  function automatic logic [11:0] get_sum(input bit sel);
    return sel ? {4'h0, sum_s} : sum_b;
  endfunction

`ifdef NIBBLE_ACC_SAT_EN
  function automatic logic get_ovf(input bit sel);
    return sel ? sum_ovf_s : sum_ovf_b;
  endfunction
`endif

  function automatic vec_t mkVec(input bit sel, input int n, input logic [7:0] p0,
                                 input logic [7:0] p1, input logic [7:0] rest,
                                 input int exp_sum, input bit exp_ovf, input bit lat);
    vec_t v;
    v.sel = sel;
    v.n   = n;
    for (int k = 0; k < 9; k++) v.pix[k] = rest;
    v.pix[0]  = p0;
    v.pix[1]  = p1;
    v.exp_sum = exp_sum;
    v.exp_ovf = exp_ovf;
    v.lat     = lat;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic drivePix(input bit sel, input logic v, input logic [7:0] d);
    if (sel) begin
      pix_valid_s = v;
      pix_data_s  = d;
    end else begin
      pix_valid_b = v;
      pix_data_b  = d;
    end
  endtask

  task automatic driveReady(input bit sel, input logic r);
    if (sel) sum_ready_s = r;
    else     sum_ready_b = r;
  endtask

  // Offers one pixel as soon as the block is ready; returns at the negedge just after acceptance.
  task automatic applyStimulus(input bit sel, input logic [7:0] p, output int acc_cyc);
    bit done = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (rdy(sel)) begin
        drivePix(sel, 1'b1, p);
        acc_cyc = cyc;
        done    = 1'b1;
      end
    end
    checkOutput("pixel accepted within bound", int'(done), 1);
    if (done) begin
      @(negedge clk);
      drivePix(sel, 1'b0, 8'h00);
      checkOutput("pix_ready low in ADD", int'(rdy(sel)), 0);
    end
  endtask

  task automatic waitSum(input bit sel, output bit got, output int seen);
    got  = 1'b0;
    seen = -1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (vld(sel)) begin
        got  = 1'b1;
        seen = cyc;
      end
    end
    checkOutput("sum_valid arrives within bound", int'(got), 1);
  endtask

  task automatic finishSum(input bit sel, input int exp_sum, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      checkOutput("sum held while not ready", int'(get_sum(sel)), exp_sum);
      checkOutput("sum_valid held while not ready", int'(vld(sel)), 1);
    end
    driveReady(sel, 1'b1);
    @(negedge clk);
    driveReady(sel, 1'b0);
    checkOutput("sum_valid drops after handshake", int'(vld(sel)), 0);
    checkOutput("pix_ready after handshake", int'(rdy(sel)), 1);
  endtask

  task automatic runWindow(input bit sel, input pix_q_t px, input int exp_sum,
                           input bit exp_ovf, input bit check_lat, input bit handshake);
    int ac, first_ac, seen;
    bit got;
    first_ac = -1;
    foreach (px[i]) begin
      applyStimulus(sel, px[i], ac);
      if (i == 0) first_ac = ac;
    end
    waitSum(sel, got, seen);
    if (got) begin
      checkOutput("window sum", int'(get_sum(sel)), exp_sum);
`ifdef NIBBLE_ACC_SAT_EN
      checkOutput("sum_ovf", int'(get_ovf(sel)), int'(exp_ovf));
`else
      if (exp_ovf) $display("[TB] note: overflow expected only with saturation enabled");
`endif
      checkOutput("pix_ready low in DONE", int'(rdy(sel)), 0);
      if (check_lat) checkOutput("sum_valid latency from first accept", seen - first_ac, 9 * 4);
      if (handshake) finishSum(sel, exp_sum, int'($urandom_range(0, 2)));
    end
  endtask

  // Reference: plain integer sum of the window, then wrap or saturate at the accumulator width.
  task automatic model(input bit sel, input pix_q_t px, output int s, output bit ovf);
    int total = 0;
    int w     = sel ? 8 : 12;
    foreach (px[i]) total += int'(px[i]);
    ovf = 1'b0;
    s   = total % (1 << w);
`ifdef NIBBLE_ACC_SAT_EN
    if (total >= (1 << w)) begin
      s   = (1 << w) - 1;
      ovf = 1'b1;
    end
`endif
  endtask

  task automatic checkResetState(input bit sel, input string tag);
    checkOutput({tag, " pix_ready"}, int'(rdy(sel)), 1);
    checkOutput({tag, " sum_valid"}, int'(vld(sel)), 0);
    checkOutput({tag, " sum"}, int'(get_sum(sel)), 0);
    checkOutput({tag, " add_a"}, int'(sel ? add_a_s : add_a_b), 0);
    checkOutput({tag, " add_b"}, int'(sel ? add_b_s : add_b_b), 0);
    checkOutput({tag, " add_c0"}, int'(sel ? add_c0_s : add_c0_b), 0);
  endtask

  function automatic pix_q_t fillQ(input int n, input logic [7:0] v);
    pix_q_t q;
    for (int i = 0; i < n; i++) q.push_back(v);
    return q;
  endfunction

  vec_t   vecs[6];
  pix_q_t q;
  int     ac, seen, exp_s;
  bit     got, exp_o;

  initial begin
    rst         = 1'b1;
    pix_valid_b = 1'b0; pix_data_b = 8'h00; sum_ready_b = 1'b0;
    pix_valid_s = 1'b0; pix_data_s = 8'h00; sum_ready_s = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checkResetState(1'b0, "reset big");
    checkResetState(1'b1, "reset small");

`ifdef NIBBLE_ACC_SAT_EN
    vecs[2] = mkVec(1'b1, 2, 8'd200, 8'd100, 8'h00, 'hFF, 1'b1, 1'b0);
    vecs[5] = mkVec(1'b1, 2, 8'h80, 8'h80, 8'h00, 'hFF, 1'b1, 1'b0);
`else
    vecs[2] = mkVec(1'b1, 2, 8'd200, 8'd100, 8'h00, 'h2C, 1'b0, 1'b0);
    vecs[5] = mkVec(1'b1, 2, 8'h80, 8'h80, 8'h00, 'h00, 1'b0, 1'b0);
`endif
    vecs[0] = mkVec(1'b0, 9, 8'hFF, 8'hFF, 8'hFF, 'h8F7, 1'b0, 1'b1);
    vecs[1] = mkVec(1'b1, 2, 8'h0F, 8'h01, 8'h00, 'h010, 1'b0, 1'b0);
    vecs[3] = mkVec(1'b0, 9, 8'h01, 8'h01, 8'h01, 9, 1'b0, 1'b0);
    vecs[4] = mkVec(1'b1, 2, 8'h80, 8'h7F, 8'h00, 'hFF, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      q = {};
      for (int j = 0; j < vecs[i].n; j++) q.push_back(vecs[i].pix[j]);
      runWindow(vecs[i].sel, q, vecs[i].exp_sum, vecs[i].exp_ovf, vecs[i].lat, 1'b1);
    end

    // Carry out of nibble 0 must reappear as carry-in on nibble 1.
    applyStimulus(1'b1, 8'h0F, ac);
    applyStimulus(1'b1, 8'h01, ac);
    checkOutput("carry trace n0 add_a", int'(add_a_s), 'hF);
    checkOutput("carry trace n0 add_b", int'(add_b_s), 'h1);
    checkOutput("carry trace n0 add_c0", int'(add_c0_s), 0);
    @(negedge clk);
    checkOutput("carry trace n1 add_a", int'(add_a_s), 'h0);
    checkOutput("carry trace n1 add_b", int'(add_b_s), 'h0);
    checkOutput("carry trace n1 add_c0", int'(add_c0_s), 1);
    waitSum(1'b1, got, seen);
    checkOutput("carry trace sum", int'(get_sum(1'b1)), 'h10);
    finishSum(1'b1, 'h10, 0);

    // Adder-port trace: acc=0x0F0 plus 0xAB.
    applyStimulus(1'b0, 8'hF0, ac);
    applyStimulus(1'b0, 8'hAB, ac);
    checkOutput("port trace n0 add_a", int'(add_a_b), 'h0);
    checkOutput("port trace n0 add_b", int'(add_b_b), 'hB);
    checkOutput("port trace n0 add_c0", int'(add_c0_b), 0);
    @(negedge clk);
    checkOutput("port trace n1 add_a", int'(add_a_b), 'hF);
    checkOutput("port trace n1 add_b", int'(add_b_b), 'hA);
    checkOutput("port trace n1 add_c0", int'(add_c0_b), 0);
    @(negedge clk);
    checkOutput("port trace n2 add_a", int'(add_a_b), 'h0);
    checkOutput("port trace n2 add_b", int'(add_b_b), 'h0);
    checkOutput("port trace n2 add_c0", int'(add_c0_b), 1);
    runWindow(1'b0, fillQ(7, 8'h00), 'h19B, 1'b0, 1'b0, 1'b1);

    // Backpressure: DONE holds its total and refuses pixels until sum_ready.
    runWindow(1'b0, fillQ(9, 8'h03), 27, 1'b0, 1'b0, 1'b0);
    drivePix(1'b0, 1'b1, 8'h55);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("backpressure sum", int'(sum_b), 27);
      checkOutput("backpressure sum_valid", int'(sum_valid_b), 1);
      checkOutput("backpressure pix_ready", int'(pix_ready_b), 0);
    end
    drivePix(1'b0, 1'b0, 8'h00);
    finishSum(1'b0, 27, 0);
    runWindow(1'b0, fillQ(9, 8'h02), 18, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a window discards the partial sum.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h11, ac);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkResetState(1'b0, "mid-window reset");
    runWindow(1'b0, fillQ(9, 8'h01), 9, 1'b0, 1'b0, 1'b1);

    for (int w = 0; w < 10; w++) begin
      bit sel;
      sel = 1'($urandom_range(0, 1));
      q   = {};
      for (int j = 0; j < (sel ? 2 : 9); j++) q.push_back(8'($urandom_range(0, 255)));
      model(sel, q, exp_s, exp_o);
      runWindow(sel, q, exp_s, exp_o, 1'b0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
